i2c_xfer_sequencer: RTL and testbench



---
 rtl/i2c_seq_pkg.sv | 37 +++
 rtl/i2c_seq_watchdog.sv | 35 +++
 rtl/i2c_xfer_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_xfer_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_pkg
// Brief    : Shared state encoding, error codes and R/W bit values for the
//            I2C transaction sequencer.
// Revision : 1.0
// ============================================================================
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_DEVW   = 4'd2,
        ST_REG    = 4'd3,
        ST_WDATA  = 4'd4,
        ST_RSTART = 4'd5,
        ST_DEVR   = 4'd6,
        ST_RDATA  = 4'd7,
        ST_STOP   = 4'd8,
        ST_FIN    = 4'd9
    } seq_state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ADDR    = 2'd1;
    localparam logic [1:0] ERR_DATA    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // States that issue one primitive and then wait for the byte core.
    function automatic logic is_prim_state(input seq_state_t s);
        return (s != ST_IDLE) && (s != ST_FIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_watchdog
// Brief    : Restartable cycle counter; flags expiry after TIMEOUT_CYC-1 ticks.
// Revision : 1.0
// ============================================================================
module i2c_seq_watchdog #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    assign expired = enable && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_xfer_sequencer
// Brief    : Register-level I2C transaction controller driving a byte core.
// Revision : 1.0
// ============================================================================
module i2c_xfer_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_dev,
    input  logic [7:0]       cmd_reg,
    input  logic             cmd_rnw,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic [1:0]       err,
    output logic             busy,
    output logic             core_start,
    output logic             core_stop,
    output logic             core_write,
    output logic             core_read,
    output logic [7:0]       core_wdata,
    output logic             core_nack,
    input  logic             core_ready,
    input  logic             core_done,
    input  logic             core_ack,
    input  logic [7:0]       core_rdata
);

    seq_state_t       r_state;
    logic             r_issued;
    logic [6:0]       r_dev;
    logic [7:0]       r_reg;
    logic             r_rnw;
    logic [LEN_W-1:0] r_len_left;

    logic w_can_issue;
    logic w_wd_en;
    logic w_wd_expired;
    logic w_last_byte;

    // WDATA additionally stalls on the host; the watchdog stays idle meanwhile.
    assign w_can_issue = is_prim_state(r_state) && !r_issued && core_ready
                         && ((r_state != ST_WDATA) || wr_valid);
    assign w_wd_en     = is_prim_state(r_state) && r_issued;
    assign w_last_byte = (r_len_left == LEN_W'(1));

    i2c_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_can_issue),
        .enable  (w_wd_en),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_issued   <= 1'b0;
            r_dev      <= '0;
            r_reg      <= '0;
            r_rnw      <= 1'b0;
            r_len_left <= '0;
            cmd_ready  <= 1'b1;
            wr_ready   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= ERR_OK;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_stop  <= 1'b0;
            core_write <= 1'b0;
            core_read  <= 1'b0;
            core_wdata <= '0;
            core_nack  <= 1'b0;
        end else begin
            core_start <= 1'b0;
            core_stop  <= 1'b0;
            core_write <= 1'b0;
            core_read  <= 1'b0;
            wr_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_dev      <= cmd_dev;
                        r_reg      <= cmd_reg;
                        r_rnw      <= cmd_rnw;
                        r_len_left <= cmd_len;
                        err        <= ERR_OK;
                        busy       <= 1'b1;
                        cmd_ready  <= 1'b0;
                        core_nack  <= 1'b0;
                        r_issued   <= 1'b0;
                        r_state    <= ST_START;
                    end
                end

                ST_FIN: begin
                    cmd_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    if (w_can_issue) begin
                        r_issued <= 1'b1;
                        case (r_state)
                            ST_START, ST_RSTART: core_start <= 1'b1;
                            ST_DEVW: begin
                                core_write <= 1'b1;
                                core_wdata <= {r_dev, RW_WRITE};
                            end
                            ST_REG: begin
                                core_write <= 1'b1;
                                core_wdata <= r_reg;
                            end
                            ST_WDATA: begin
                                core_write <= 1'b1;
                                core_wdata <= wr_data;
                                wr_ready   <= 1'b1;
                            end
                            ST_DEVR: begin
                                core_write <= 1'b1;
                                core_wdata <= {r_dev, RW_READ};
                            end
                            ST_RDATA: begin
                                core_read <= 1'b1;
                                core_nack <= w_last_byte;
                            end
                            ST_STOP: core_stop <= 1'b1;
                            default: ;
                        endcase
                    end else if (r_issued && core_done) begin
                        r_issued <= 1'b0;
                        case (r_state)
                            ST_START:  r_state <= ST_DEVW;
                            ST_RSTART: r_state <= ST_DEVR;
                            ST_DEVW: begin
                                if (!core_ack) begin
                                    err     <= ERR_ADDR;
                                    r_state <= ST_STOP;
                                end else begin
                                    r_state <= ST_REG;
                                end
                            end
                            ST_REG: begin
                                if (!core_ack) begin
                                    err     <= ERR_DATA;
                                    r_state <= ST_STOP;
                                end else if (r_len_left == '0) begin
                                    r_state <= ST_STOP;
                                end else if (r_rnw == RW_READ) begin
                                    r_state <= ST_RSTART;
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end
                            ST_WDATA: begin
                                r_len_left <= r_len_left - LEN_W'(1);
                                if (!core_ack) begin
                                    err     <= ERR_DATA;
                                    r_state <= ST_STOP;
                                end else if (w_last_byte) begin
                                    r_state <= ST_STOP;
                                end
                            end
                            ST_DEVR: begin
                                if (!core_ack) begin
                                    err     <= ERR_ADDR;
                                    r_state <= ST_STOP;
                                end else begin
                                    r_state <= ST_RDATA;
                                end
                            end
                            ST_RDATA: begin
                                rd_data    <= core_rdata;
                                rd_valid   <= 1'b1;
                                r_len_left <= r_len_left - LEN_W'(1);
                                if (w_last_byte) begin
                                    r_state <= ST_STOP;
                                end
                            end
                            ST_STOP: begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= ST_FIN;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end else if (w_wd_expired) begin
                        // Core presumed hung: skip STOP and finish immediately.
                        err      <= ERR_TIMEOUT;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_issued <= 1'b0;
                        r_state  <= ST_FIN;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_xfer_sequencer
// Brief    : Directed transaction table against a behavioural byte core.
// Revision : 1.0
// ============================================================================
module tb_i2c_xfer_sequencer;
    import i2c_seq_pkg::*;

    localparam int LEN_W       = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam logic [7:0] K_S = 8'h53;
    localparam logic [7:0] K_P = 8'h50;
    localparam logic [7:0] K_W = 8'h57;
    localparam logic [7:0] K_R = 8'h52;
    localparam int NVEC = 9;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid, cmd_ready, cmd_rnw;
    logic [6:0]       cmd_dev;
    logic [7:0]       cmd_reg;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       wr_data;
    logic             wr_valid, wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid, done, busy;
    logic [1:0]       err;
    logic             core_start, core_stop, core_write, core_read, core_nack;
    logic [7:0]       core_wdata, core_rdata;
    logic             core_ready, core_done, core_ack;

    always #5 clk = ~clk;

    i2c_xfer_sequencer #(
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dev    (cmd_dev),
        .cmd_reg    (cmd_reg),
        .cmd_rnw    (cmd_rnw),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .core_start (core_start),
        .core_stop  (core_stop),
        .core_write (core_write),
        .core_read  (core_read),
        .core_wdata (core_wdata),
        .core_nack  (core_nack),
        .core_ready (core_ready),
        .core_done  (core_done),
        .core_ack   (core_ack),
        .core_rdata (core_rdata)
    );

    typedef struct {
        logic             rnw;
        logic [6:0]       dev;
        logic [7:0]       rg;
        logic [LEN_W-1:0] len;
        logic [3:0][7:0]  pay;
        int               nack_at;
        logic [1:0]       eerr;
        int               nwrr;
        int               nrd;
        int               ntr;
        logic [11:0][15:0] tr;
    } vec_t;

    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Byte-core model / monitor bookkeeping (cumulative; main keeps bases).
    logic [15:0]     tr_log [512];
    logic [7:0]      rd_log [64];
    int              n_tr = 0, n_w = 0, n_r = 0, n_rd = 0, n_wrr = 0;
    int              hang_cyc = 0;
    logic [3:0][7:0] cur_pay = '0;
    int              cur_nack_at = -1, cur_hang_at = -1;
    int              w_base = 0, r_base = 0, wrr_base = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic rnw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [LEN_W-1:0] len,
                           input logic [31:0] pay, input int nack_at,
                           input logic [1:0] eerr, input int nwrr, input int nrd);
        vecs[i].rnw = rnw; vecs[i].dev = dev; vecs[i].rg = rg; vecs[i].len = len;
        vecs[i].pay = pay; vecs[i].nack_at = nack_at; vecs[i].eerr = eerr;
        vecs[i].nwrr = nwrr; vecs[i].nrd = nrd; vecs[i].ntr = 0; vecs[i].tr = '0;
    endtask

    task automatic push(input int i, input logic [7:0] kind, input logic [7:0] dat);
        vecs[i].tr[vecs[i].ntr] = {kind, dat};
        vecs[i].ntr++;
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : host_monitor
        logic [1:0] wi;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rd_valid) begin
                    rd_log[6'(n_rd)] = rd_data;
                    n_rd++;
                end
                if (wr_ready) n_wrr++;
            end
            wi = 2'(n_wrr - wrr_base);
            wr_data = cur_pay[wi];
        end
    end

    initial begin : byte_core
        logic [7:0] kind, dat, rdat;
        logic [1:0] ri;
        bit hang, ack;
        core_ready = 1'b1; core_done = 1'b0; core_ack = 1'b0; core_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n && (core_start || core_stop || core_write || core_read)) begin
                hang = 0; ack = 1; dat = 8'h00; rdat = 8'h00;
                if (core_start)      kind = K_S;
                else if (core_stop)  kind = K_P;
                else if (core_write) kind = K_W;
                else                 kind = K_R;
                if (core_write) begin
                    dat = core_wdata;
                    if (n_w - w_base == cur_nack_at) ack = 0;
                    if (n_w - w_base == cur_hang_at) begin
                        hang = 1;
                        hang_cyc = cyc;
                    end
                    n_w++;
                end
                if (core_read) begin
                    dat  = {7'b0, core_nack};
                    ri   = 2'(n_r - r_base);
                    rdat = cur_pay[ri];
                    n_r++;
                end
                tr_log[9'(n_tr)] = {kind, dat};
                n_tr++;
                core_ready = 1'b0;
                if (hang) begin
                    repeat (24) @(negedge clk);
                end else begin
                    @(negedge clk);
                    core_done = 1'b1; core_ack = ack; core_rdata = rdat;
                    @(negedge clk);
                    core_done = 1'b0; core_ack = 1'b0;
                end
                core_ready = 1'b1;
            end
        end
    end

    task automatic chk_reset_vals(input string name);
        chk({name, "_ctl"}, {cmd_ready, busy, done, err, rd_valid, wr_ready},
            {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
        chk({name, "_core"}, {core_start, core_stop, core_write, core_read, core_nack},
            5'b0);
        chk({name, "_data"}, {core_wdata, rd_data}, 16'h0000);
    endtask

    task automatic issue_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [LEN_W-1:0] len, input logic [31:0] pay,
                             input int nack_at, input int hang_at);
        cur_pay = pay; cur_nack_at = nack_at; cur_hang_at = hang_at;
        w_base = n_w; r_base = n_r; wrr_base = n_wrr;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_dev = dev; cmd_reg = rg; cmd_len = len;
        for (int t = 0; t < 200 && !cmd_ready; t++) @(negedge clk);
        chk("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        chk("done_seen", ok, 1);
    endtask

    task automatic run_vec(input int i);
        bit ok;
        int tb0, rb0;
        tb0 = n_tr; rb0 = n_rd;
        issue_cmd(vecs[i].rnw, vecs[i].dev, vecs[i].rg, vecs[i].len, vecs[i].pay,
                  vecs[i].nack_at, -1);
        wait_done(ok);
        chk($sformatf("v%0d_err", i), err, vecs[i].eerr);
        @(negedge clk);
        chk($sformatf("v%0d_idle", i), {done, busy, cmd_ready}, 3'b001);
        chk($sformatf("v%0d_nprims", i), n_tr - tb0, vecs[i].ntr);
        for (int k = 0; k < vecs[i].ntr; k++)
            chk($sformatf("v%0d_prim%0d", i, k), tr_log[9'(tb0 + k)], vecs[i].tr[k]);
        chk($sformatf("v%0d_wr_ready_cnt", i), n_wrr - wrr_base, vecs[i].nwrr);
        chk($sformatf("v%0d_rd_cnt", i), n_rd - rb0, vecs[i].nrd);
        for (int k = 0; k < vecs[i].nrd; k++)
            chk($sformatf("v%0d_rd%0d", i, k), rd_log[6'(rb0 + k)], vecs[i].pay[k]);
    endtask

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin : main
        bit ok;
        int tb0;
        cmd_valid = 0; cmd_rnw = 0; cmd_dev = '0; cmd_reg = '0; cmd_len = '0;
        wr_valid = 1'b1;

        // rnw dev reg len payload nack_at err wr_ready rd
        set_vec(0, 0, 7'h50, 8'h10, 4'd2, 32'h0000_55AA, -1, ERR_OK, 2, 0);
        push(0, K_S, 8'h00); push(0, K_W, 8'hA0); push(0, K_W, 8'h10);
        push(0, K_W, 8'hAA); push(0, K_W, 8'h55); push(0, K_P, 8'h00);
        set_vec(1, 1, 7'h50, 8'h20, 4'd3, 32'h0033_2211, -1, ERR_OK, 0, 3);
        push(1, K_S, 8'h00); push(1, K_W, 8'hA0); push(1, K_W, 8'h20);
        push(1, K_S, 8'h00); push(1, K_W, 8'hA1); push(1, K_R, 8'h00);
        push(1, K_R, 8'h00); push(1, K_R, 8'h01); push(1, K_P, 8'h00);
        set_vec(2, 0, 7'h3C, 8'h10, 4'd2, 32'h0000_0201, 0, ERR_ADDR, 0, 0);
        push(2, K_S, 8'h00); push(2, K_W, 8'h78); push(2, K_P, 8'h00);
        set_vec(3, 1, 7'h50, 8'h05, 4'd0, 32'h0, -1, ERR_OK, 0, 0);
        push(3, K_S, 8'h00); push(3, K_W, 8'hA0); push(3, K_W, 8'h05); push(3, K_P, 8'h00);
        set_vec(4, 0, 7'h21, 8'h33, 4'd3, 32'h000C_0B0A, 2, ERR_DATA, 1, 0);
        push(4, K_S, 8'h00); push(4, K_W, 8'h42); push(4, K_W, 8'h33);
        push(4, K_W, 8'h0A); push(4, K_P, 8'h00);
        set_vec(5, 1, 7'h7F, 8'h01, 4'd1, 32'h0000_005A, 2, ERR_ADDR, 0, 0);
        push(5, K_S, 8'h00); push(5, K_W, 8'hFE); push(5, K_W, 8'h01);
        push(5, K_S, 8'h00); push(5, K_W, 8'hFF); push(5, K_P, 8'h00);
        set_vec(6, 0, 7'h00, 8'hFF, 4'd0, 32'h0, -1, ERR_OK, 0, 0);
        push(6, K_S, 8'h00); push(6, K_W, 8'h00); push(6, K_W, 8'hFF); push(6, K_P, 8'h00);
        set_vec(7, 1, 7'h11, 8'h80, 4'd1, 32'h0000_00C3, -1, ERR_OK, 0, 1);
        push(7, K_S, 8'h00); push(7, K_W, 8'h22); push(7, K_W, 8'h80);
        push(7, K_S, 8'h00); push(7, K_W, 8'h23); push(7, K_R, 8'h01); push(7, K_P, 8'h00);
        set_vec(8, 0, 7'h50, 8'h10, 4'd1, 32'h0000_0077, 1, ERR_DATA, 0, 0);
        push(8, K_S, 8'h00); push(8, K_W, 8'hA0); push(8, K_W, 8'h10); push(8, K_P, 8'h00);

        repeat (3) @(negedge clk);
        chk_reset_vals("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset_released");

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Watchdog: core never completes the DEVW write.
        tb0 = n_tr;
        issue_cmd(0, 7'h50, 8'h10, 4'd1, 32'h77, -1, 0);
        wait_done(ok);
        chk("to_err", err, ERR_TIMEOUT);
        chk("to_latency", cyc - hang_cyc, TIMEOUT_CYC);
        repeat (3) @(negedge clk);
        chk("to_nprims_no_stop", n_tr - tb0, 2);
        chk("to_last_prim", tr_log[9'(tb0 + 1)], {K_W, 8'hA0});
        run_vec(0);

        // Host stalls far longer than the watchdog period before supplying data.
        wr_valid = 1'b0;
        tb0 = n_tr;
        issue_cmd(0, 7'h2A, 8'h44, 4'd1, 32'h99, -1, -1);
        for (int t = 0; t < 200 && (n_w - w_base) < 2; t++) @(negedge clk);
        repeat (40) @(negedge clk);
        chk("stall_parked", {busy, done, 4'(n_w - w_base)}, {1'b1, 1'b0, 4'd2});
        wr_valid = 1'b1;
        wait_done(ok);
        chk("stall_err", err, ERR_OK);
        @(negedge clk);
        chk("stall_nprims", n_tr - tb0, 5);
        chk("stall_data", tr_log[9'(tb0 + 3)], {K_W, 8'h99});

        // Asynchronous reset while parked in WDATA.
        wr_valid = 1'b0;
        issue_cmd(0, 7'h50, 8'h10, 4'd3, 32'h0033_2211, -1, -1);
        for (int t = 0; t < 200 && (n_w - w_base) < 2; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        tb0 = n_tr;
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        wr_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_no_stop", n_tr - tb0, 0);
        run_vec(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
